// File: rtl/instr_encoder_pkg.sv
// Constants shared with the core decoder: RV32 opcodes, funct3 codes and the
// command codes understood by the instruction encoder.
package instr_encoder_pkg;

  localparam logic [6:0] OpcodeLui       = 7'b0110111;
  localparam logic [6:0] OpcodeImmediate = 7'b0010011;
  localparam logic [6:0] OpcodeSystem    = 7'b1110011;

  localparam logic [2:0] Funct3Addi   = 3'b000;
  localparam logic [2:0] Funct3Csrrw  = 3'b001;
  localparam logic [2:0] Funct3Csrrs  = 3'b010;
  localparam logic [2:0] Funct3Csrrwi = 3'b101;

  localparam logic [31:0] NopWord    = 32'h0000_0013;
  localparam logic [31:0] EbreakWord = 32'h0010_0073;
  localparam logic [31:0] WfiWord    = 32'h1050_0073;

  typedef enum logic [2:0] {
    EncNop    = 3'd0,
    EncLi     = 3'd1,
    EncCsrr   = 3'd2,
    EncCsrw   = 3'd3,
    EncCsrwi  = 3'd4,
    EncEbreak = 3'd5,
    EncWfi    = 3'd6,
    EncRsvd   = 3'd7
  } enc_op_e;

endpackage

// File: rtl/instr_encoder_wires_pkg.sv
// Bundled request/response views of the instruction encoder interface.
package instr_encoder_wires_pkg;
  import instr_encoder_pkg::*;

  typedef struct packed {
    logic        valid;
    enc_op_e     op;
    logic [4:0]  rd_rs;
    logic [11:0] csr;
    logic [31:0] data;
  } instr_encoder_in_type;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic        last;
    logic        err;
  } instr_encoder_out_type;

endpackage

// File: rtl/instr_encoder.sv
// Turns simple commands (NOP, LI, CSR access, EBREAK, WFI) into one or two
// RV32 instruction words streamed out over a valid/ready handshake.
module instr_encoder
  import instr_encoder_pkg::*;
  import instr_encoder_wires_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [4:0]  req_reg,
  input  logic [11:0] req_csr,
  input  logic [31:0] req_data,
  output logic        req_ready,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic        instr_last,
  input  logic        instr_ready,
  output logic        err
);

  typedef enum logic [1:0] {StIdle, StEmit1, StEmit2} state_e;

  state_e                state_q;
  instr_encoder_in_type  req;
  instr_encoder_out_type out_q;
  logic [31:0]           word2_q;

  logic [31:0] word1, word2;
  logic        last1, rsvd, accept;
  logic [11:0] li_lo;
  logic [19:0] li_hi;
  logic        li_fits;

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rd, opc};
  endfunction

  assign req = '{valid: req_valid, op: enc_op_e'(req_op), rd_rs: req_reg, csr: req_csr,
                 data: req_data};

  assign req_ready = (state_q == StIdle);
  assign accept    = req.valid && req_ready;

  always_comb begin
    // (data + 0x800)[31:12] without a full 32-bit add: carry only from bit 11.
    li_hi   = req.data[31:12] + {19'b0, req.data[11]};
    li_lo   = req.data[11:0];
    li_fits = (&req.data[31:11]) | ~(|req.data[31:11]);
    word1   = NopWord;
    word2   = NopWord;
    last1   = 1'b1;
    rsvd    = 1'b0;
    unique case (req.op)
      EncNop: ;
      EncLi: begin
        if (req.rd_rs != 5'd0) begin
          if (li_fits) begin
            word1 = enc_i(li_lo, 5'd0, Funct3Addi, req.rd_rs, OpcodeImmediate);
          end else begin
            word1 = enc_u(li_hi, req.rd_rs, OpcodeLui);
            word2 = enc_i(li_lo, req.rd_rs, Funct3Addi, req.rd_rs, OpcodeImmediate);
            last1 = (li_lo == 12'd0);
          end
        end
      end
      EncCsrr:   word1 = enc_i(req.csr, 5'd0, Funct3Csrrs, req.rd_rs, OpcodeSystem);
      EncCsrw:   word1 = enc_i(req.csr, req.rd_rs, Funct3Csrrw, 5'd0, OpcodeSystem);
      EncCsrwi:  word1 = enc_i(req.csr, req.data[4:0], Funct3Csrrwi, 5'd0, OpcodeSystem);
      EncEbreak: word1 = EbreakWord;
      EncWfi:    word1 = WfiWord;
      EncRsvd:   rsvd  = 1'b1;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      out_q   <= '0;
      word2_q <= '0;
    end else begin
      out_q.err <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (rsvd) begin
              out_q.err <= 1'b1;
            end else begin
              state_q     <= StEmit1;
              out_q.valid <= 1'b1;
              out_q.instr <= word1;
              out_q.last  <= last1;
              word2_q     <= word2;
            end
          end
        end
        StEmit1: begin
          if (instr_ready) begin
            if (out_q.last) begin
              state_q     <= StIdle;
              out_q.valid <= 1'b0;
              out_q.instr <= '0;
              out_q.last  <= 1'b0;
            end else begin
              state_q     <= StEmit2;
              out_q.instr <= word2_q;
              out_q.last  <= 1'b1;
            end
          end
        end
        StEmit2: begin
          if (instr_ready) begin
            state_q     <= StIdle;
            out_q.valid <= 1'b0;
            out_q.instr <= '0;
            out_q.last  <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign instr_valid = out_q.valid;
  assign instr       = out_q.instr;
  assign instr_last  = out_q.last;
  assign err         = out_q.err;

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Port clock, input, 1: single clock; all state updates on the rising edge.
REQ-002 Port reset, input, 1: asynchronous, active-high reset.
REQ-003 Port req_valid, input, 1: a command is presented.
REQ-004 Port req_op, input, 3: command code: 0 NOP, 1 LI, 2 CSRR, 3 CSRW, 4 CSRWI, 5 EBREAK, 6 WFI, 7 reserved.
REQ-005 Port req_reg, input, 5: rd for LI/CSRR; rs1 for CSRW.
REQ-006 Port req_csr, input, 12: CSR address for CSRR/CSRW/CSRWI.
REQ-007 Port req_data, input, 32: immediate for LI; bits [4:0] are the uimm for CSRWI.
REQ-008 Port req_ready, output, 1: the block can accept a command this cycle.
REQ-009 Port instr_valid, output, 1: instr holds a valid encoded RV32 instruction.
REQ-010 Port instr, output, 32: the encoded instruction word.
REQ-011 Port instr_last, output, 1: instr is the final word of the current command.
REQ-012 Port instr_ready, input, 1: the downstream consumer accepts instr this cycle.
REQ-013 Port err, output, 1: one-cycle pulse when a reserved req_op is accepted.

Function
REQ-014 The FSM SHALL have states IDLE, EMIT1 and EMIT2; req_ready SHALL be 1 only in IDLE.
REQ-015 A command SHALL be accepted on req_valid&req_ready; the request fields SHALL be registered at acceptance and ignored afterwards.
REQ-016 instr_valid SHALL assert in the cycle after acceptance (latency 1); no other path to instr_valid SHALL exist.
REQ-017 While instr_valid=1 and instr_ready=0, instr, instr_last and the state SHALL hold stable.
REQ-018 A word SHALL transfer on instr_valid&instr_ready. A transfer with instr_last=1 SHALL return the FSM to IDLE, so req_ready is 1 in the next cycle; accept and emit never overlap.
REQ-019 NOP SHALL emit 0x00000013 (last=1).
REQ-020 LI: let lo=req_data[11:0] sign-extended and hi=(req_data+0x800)[31:12], computed mod 2^32.
- If req_data fits in a 12-bit signed value: emit addi rd,x0,lo only.
- Otherwise: emit lui rd,hi; then addi rd,rd,lo, unless lo=0, in which case lui is last.
- If rd=x0: emit 0x00000013 only.
REQ-021 CSRR SHALL emit csrrs rd,csr,x0. CSRW SHALL emit csrrw x0,csr,rs1. CSRWI SHALL emit csrrwi x0,csr,uimm. All are single words.
REQ-022 EBREAK SHALL emit 0x00100073; WFI SHALL emit 0x10500073; both single words.
REQ-023 For reserved op 7: err SHALL pulse for the one cycle after acceptance; no word is emitted and the FSM stays in IDLE.
REQ-024 Encodings SHALL use the standard RV32 opcode_lui, opcode_immediate and opcode_system field layouts decoded elsewhere in the core.

Reset
REQ-025 Asserting reset SHALL force the state to IDLE and set instr_valid=0, instr_last=0, instr=0, err=0 and req_ready=1 immediately, without waiting for clock.
REQ-026 Reset asserted mid-command SHALL discard the pending words; after release, the first accepted command SHALL encode normally.

Structure
REQ-027 The enc_op command codes SHALL be defined in the constants package.
REQ-028 instr_encoder_in_type and instr_encoder_out_type SHALL be defined in the wires package.
REQ-029 Opcode and funct constants SHALL be reused from the constants package and not redefined.
REQ-030 The block SHALL be a single module with no sub-module; the instruction-format builders SHALL be local functions.

Verification
REQ-031 LI x5,0x12345678 with instr_ready=1 -> 0x123452B7 (last=0), then 0x67828293 (last=1); req_ready=1 in the following cycle.
REQ-032 LI x1,0x00000FFF -> 0x000010B7, then 0xFFF08093. LI x2,0xFFFFFFFB -> single word 0xFFB00113. LI x3,0x12345000 -> single lui 0x123451B7 with last=1.
REQ-033 CSRR x10,0x300 -> 0x30002573. CSRW 0x305 from x11 -> 0x30559073. Both single words with last=1.
REQ-034 LI x5,0x12345678 with instr_ready held 0 for 3 cycles -> 0x123452B7 stable all 3 cycles; req_ready=0 throughout; the second word follows only after the first transfers.
REQ-035 req_op=7 -> err=1 for exactly one cycle, instr_valid stays 0. Reset asserted during the first LI word -> outputs clear asynchronously; a following NOP emits 0x00000013.
